// File: rtl/echo_pipe_pkg.sv
// echo_pipe_pkg
//   Shared constants for the request message pipe between the request
//   serializer and the request deserializer.
//   MSG_WIDTH         : width of one tagged message word
//   TAG_MSB / TAG_LSB : position of the 32-bit dispatch tag in the word
//   TAG_SAY / TAG_SAY2: tag values selecting the say / say2 methods
package echo_pipe_pkg;

  localparam int unsigned MSG_WIDTH = 192;
  localparam int unsigned TAG_MSB   = 191;
  localparam int unsigned TAG_LSB   = 160;

  localparam logic [31:0] TAG_SAY   = 32'd1;
  localparam logic [31:0] TAG_SAY2  = 32'd2;

endpackage

// File: rtl/echo_pipe_stats.sv
// echo_pipe_stats
//   Per-tag message counters for messages leaving the echo pipe FIFO.
//   Only present when ECHO_PIPE_STATS_EN is defined.
//   Ports:
//     CLK        in   clock, all state on posedge
//     RST        in   synchronous active-high reset, clears all counters
//     ena        in   a message is forwarded downstream this cycle
//     tag        in   32-bit tag of the forwarded message
//     stat_say   out  count of forwarded tag==TAG_SAY messages (saturating)
//     stat_say2  out  count of forwarded tag==TAG_SAY2 messages (saturating)
//     stat_other out  count of forwarded messages with any other tag (saturating)
`ifdef ECHO_PIPE_STATS_EN
module echo_pipe_stats
  import echo_pipe_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ena,
  input  logic [31:0] tag,
  output logic [15:0] stat_say,
  output logic [15:0] stat_say2,
  output logic [15:0] stat_other
);

  logic hit_say;
  logic hit_say2;
  logic hit_other;

  always_comb begin
    hit_say   = ena && (tag == TAG_SAY);
    hit_say2  = ena && (tag == TAG_SAY2);
    hit_other = ena && (tag != TAG_SAY) && (tag != TAG_SAY2);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_say   <= '0;
      stat_say2  <= '0;
      stat_other <= '0;
    end else begin
      if (hit_say && (stat_say != '1))
        stat_say <= stat_say + 16'd1;
      if (hit_say2 && (stat_say2 != '1))
        stat_say2 <= stat_say2 + 16'd1;
      if (hit_other && (stat_other != '1))
        stat_other <= stat_other + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/echo_pipe_fifo.sv
// echo_pipe_fifo
//   Elastic buffer between the request serializer and the request
//   deserializer. Holds up to DEPTH tagged message words and pushes the head
//   word downstream whenever it holds data and the downstream side is ready.
//   Tags are forwarded untouched; they never affect data flow.
//   Optional feature: define ECHO_PIPE_STATS_EN to add per-tag counters.
//   Ports:
//     CLK           in   clock, all state on posedge
//     RST           in   synchronous active-high reset; drops buffered words
//     in_enq__ENA   in   upstream writes in_enq_v this cycle
//     in_enq_v      in   message word
//     in_enq__RDY   out  FIFO not full
//     out_enq__ENA  out  head word accepted downstream this cycle
//     out_enq_v     out  head word (zero when empty)
//     out_enq__RDY  in   downstream ready (may depend on out_enq_v tag)
//     count         out  occupancy, 0..DEPTH
//     stat_say / stat_say2 / stat_other  out  (ECHO_PIPE_STATS_EN only)
module echo_pipe_fifo
  import echo_pipe_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = MSG_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_enq__ENA,
  input  logic [WIDTH-1:0]         in_enq_v,
  output logic                     in_enq__RDY,
  output logic                     out_enq__ENA,
  output logic [WIDTH-1:0]         out_enq_v,
  input  logic                     out_enq__RDY,
  output logic [$clog2(DEPTH):0]   count
`ifdef ECHO_PIPE_STATS_EN
  ,
  output logic [15:0]              stat_say,
  output logic [15:0]              stat_say2,
  output logic [15:0]              stat_other
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             not_empty;
  logic             wr_en;
  logic             rd_en;

  // RDY depends only on stored occupancy, so a full FIFO refuses a write
  // even in a cycle where the head is being drained.
  always_comb begin
    not_empty    = (count != '0);
    in_enq__RDY  = (count != FULL);
    wr_en        = in_enq__ENA && in_enq__RDY;
    rd_en        = not_empty && out_enq__RDY;
    out_enq__ENA = rd_en;
    out_enq_v    = not_empty ? mem[rd_ptr] : '0;
  end

  // Storage is not reset; count gates visibility of stale contents.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en)
      mem[wr_ptr] <= in_enq_v;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ECHO_PIPE_STATS_EN
  echo_pipe_stats u_stats (
    .CLK        (CLK),
    .RST        (RST),
    .ena        (out_enq__ENA),
    .tag        (out_enq_v[WIDTH-1 -: 32]),
    .stat_say   (stat_say),
    .stat_say2  (stat_say2),
    .stat_other (stat_other)
  );
`endif

endmodule

// File: tb/tb_echo_pipe_fifo.sv
// tb_echo_pipe_fifo
//   Directed self-checking bench for echo_pipe_fifo (DEPTH=4, WIDTH=192).
//   Inputs are driven 1ns after the rising edge and outputs are sampled
//   1ns later, away from the active edge.
module tb_echo_pipe_fifo;

  localparam int unsigned W = 192;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_ena;
  logic [W-1:0] in_v;
  logic         in_rdy;
  logic         out_ena;
  logic [W-1:0] out_v;
  logic         out_rdy;
  logic [2:0]   count;
`ifdef ECHO_PIPE_STATS_EN
  logic [15:0]  stat_say;
  logic [15:0]  stat_say2;
  logic [15:0]  stat_other;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 CLK = ~CLK;

  echo_pipe_fifo #(.DEPTH(4), .WIDTH(W)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq__RDY  (in_rdy),
    .out_enq__ENA (out_ena),
    .out_enq_v    (out_v),
    .out_enq__RDY (out_rdy),
    .count        (count)
`ifdef ECHO_PIPE_STATS_EN
    ,
    .stat_say     (stat_say),
    .stat_say2    (stat_say2),
    .stat_other   (stat_other)
`endif
  );

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [W-1:0] mk(input logic [31:0] tag, input logic [31:0] a, input logic [31:0] b);
    return {tag, a, b, 96'd0};
  endfunction

  logic [W-1:0] w [4];
  logic [W-1:0] s [21];
  logic [W-1:0] z;

  initial begin
    RST = 1'b1; in_ena = 1'b0; in_v = '0; out_rdy = 1'b0;
    step(); step();
    RST = 1'b0;
    #1;
    check_val("rst_count", count, 0);
    check_val("rst_in_rdy", in_rdy, 1);
    check_val("rst_out_ena", out_ena, 0);
    check_val("rst_out_v", out_v, 0);

    // single word, downstream stalled then released
    in_v = mk(32'd1, 32'hA, 32'hB); in_ena = 1'b1;
    #1;
    check_val("no_bypass_ena", out_ena, 0);
    check_val("no_bypass_v", out_v, 0);
    step();
    in_ena = 1'b0; #1;
    check_val("one_count", count, 1);
    check_val("one_out_v", out_v, mk(32'd1, 32'hA, 32'hB));
    check_val("one_stalled_ena", out_ena, 0);
    out_rdy = 1'b1; #1;
    check_val("one_release_ena", out_ena, 1);
    step();
    out_rdy = 1'b0; #1;
    check_val("one_drained_count", count, 0);
    check_val("one_drained_ena", out_ena, 0);

    // fill to DEPTH with downstream stalled
    for (int i = 0; i < 4; i++) w[i] = mk(32'd1 + 32'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
    for (int i = 0; i < 4; i++) begin
      in_v = w[i]; in_ena = 1'b1;
      step();
    end
    in_ena = 1'b0; #1;
    check_val("full_count", count, 4);
    check_val("full_in_rdy", in_rdy, 0);
    check_val("full_head", out_v, w[0]);
    // caller error: write while full must be dropped
    in_v = mk(32'hDEAD, 32'hBEEF, 32'hCAFE); in_ena = 1'b1;
    step();
    in_ena = 1'b0; #1;
    check_val("full_ignored_count", count, 4);
    check_val("full_ignored_head", out_v, w[0]);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("drain_ena", out_ena, 1);
      check_val("drain_v", out_v, w[i]);
      if (i == 0) check_val("full_read_in_rdy", in_rdy, 0);
      if (i == 1) check_val("after_read_in_rdy", in_rdy, 1);
      step();
    end
    #1;
    check_val("drained_count", count, 0);
    check_val("drained_ena", out_ena, 0);
    check_val("drained_v", out_v, 0);
    out_rdy = 1'b0;

    // streaming: one write and one read per cycle, alternating tags
    for (int i = 0; i <= 20; i++) s[i] = mk((i % 2 == 0) ? 32'd1 : 32'd2, 32'(i), 32'h5A5A0000 + 32'(i));
    in_v = s[0]; in_ena = 1'b1;
    step();
    out_rdy = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      in_ena = (i < 20);
      in_v   = s[i];
      #1;
      check_val("stream_count", count, 1);
      check_val("stream_ena", out_ena, 1);
      check_val("stream_v", out_v, s[i-1]);
      step();
    end
    in_ena = 1'b0; #1;
    check_val("stream_end_count", count, 0);
    out_rdy = 1'b0;

    // reset while half full discards buffered words
    in_v = mk(32'd1, 32'h11, 32'h11); in_ena = 1'b1; step();
    in_v = mk(32'd2, 32'h22, 32'h22); step();
    in_ena = 1'b0; #1;
    check_val("half_count", count, 2);
    RST = 1'b1;
    step();
    RST = 1'b0; out_rdy = 1'b1; #1;
    check_val("midrst_count", count, 0);
    check_val("midrst_ena", out_ena, 0);
    check_val("midrst_v", out_v, 0);
    check_val("midrst_in_rdy", in_rdy, 1);
    z = mk(32'd7, 32'h77, 32'h77);
    out_rdy = 1'b0; in_v = z; in_ena = 1'b1;
    step();
    in_ena = 1'b0; #1;
    check_val("post_rst_count", count, 1);
    check_val("post_rst_head", out_v, z);

`ifdef ECHO_PIPE_STATS_EN
    RST = 1'b1; step(); RST = 1'b0; #1;
    check_val("stat_rst_say", stat_say, 0);
    check_val("stat_rst_say2", stat_say2, 0);
    check_val("stat_rst_other", stat_other, 0);
    out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_v = mk((i < 3) ? 32'd1 : ((i < 5) ? 32'd2 : 32'd7), 32'(i), 32'd0);
      in_ena = 1'b1;
      step();
    end
    in_ena = 1'b0;
    step(); step();
    check_val("stat_say", stat_say, 3);
    check_val("stat_say2", stat_say2, 2);
    check_val("stat_other", stat_other, 1);
    out_rdy = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
